// File: rtl/barrel_shift_arbiter_if.sv
// Request/response bundle between the requesting engines, the shared shifter
// and barrel_shift_arbiter.
//
// Handshake rules, for both the request port and the response port:
//   - A transfer happens on a rising clk edge where valid and ready are both 1.
//   - A producer that raises valid keeps valid and its payload stable until the
//     transfer happens.
//   - ready may depend combinationally on valid, but valid never depends on ready.
//   - req_ready is one-hot or zero. It names the requester that the arbiter
//     would accept on this edge.
interface barrel_shift_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int AMT_W   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  // requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*AMT_W-1:0]  req_b;

  // shifter side
  logic [DATA_W-1:0]         sh_a;
  logic [AMT_W-1:0]          sh_b;
  logic [DATA_W-1:0]         sh_result;

  // response side
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;

  // status
  logic                      busy;

  // The arbiter itself
  modport slave (
    input  req_valid, req_a, req_b, sh_result, rsp_ready,
    output req_ready, sh_a, sh_b, rsp_valid, rsp_data, rsp_id, busy
  );

  // Everything around the arbiter: requesters, shifter and response consumer
  modport master (
    output req_valid, req_a, req_b, sh_result, rsp_ready,
    input  req_ready, sh_a, sh_b, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter and two-stage pipeline in front of one shared
// combinational barrel shifter.
// S1 holds the winning operand and amount on sh_a/sh_b. S2 captures sh_result
// and presents it with the requester index on a backpressurable response port.
module barrel_shift_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int AMT_W   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                   clk,
  input logic                   rst_n,
  barrel_shift_arbiter_if.slave bus
);

  // Stage S1 (issue): drives the shifter inputs directly
  logic                s1_valid;
  logic [DATA_W-1:0]   s1_a;
  logic [AMT_W-1:0]    s1_b;
  logic [ID_W-1:0]     s1_id;

  // Stage S2 (response)
  logic                s2_valid;
  logic [DATA_W-1:0]   s2_data;
  logic [ID_W-1:0]     s2_id;

  // Round-robin pointer: the most recently accepted requester
  logic [ID_W-1:0]     last_grant;

  // Arbitration and pipeline control
  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  int                  cand;
  logic [ID_W-1:0]     cand_id;
  logic [DATA_W-1:0]   sel_a;
  logic [AMT_W-1:0]    sel_b;
  logic [NUM_REQ-1:0]  ready_vec;
  logic                s2_load;
  logic                s2_drain;
  logic                s1_free;
  logic                accept;

  // S2 takes S1 whenever S2 is empty or is being emptied on this edge.
  // S1 can accept when it is empty or is moving into S2 on this edge.
  // Both stages can therefore move in the same cycle without a bubble.
  assign s2_load  = s1_valid && (!s2_valid || bus.rsp_ready);
  assign s2_drain = s2_valid && bus.rsp_ready;
  assign s1_free  = !s1_valid || s2_load;

  // Search for the first valid requester, starting just after last_grant and wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_id     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_id = ID_W'(cand);
      if (!grant_found && bus.req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_idx   = cand_id;
      end
    end
  end

  // Select the winning requester's operand and shift amount
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = bus.req_a[i*DATA_W +: DATA_W];
        sel_b = bus.req_b[i*AMT_W +: AMT_W];
      end
    end
  end

  // Offer ready only to the winner, and only when S1 can take it.
  // rst_n gates the offer so that ready drops the moment reset asserts,
  // even though the stages would otherwise look free.
  always_comb begin
    ready_vec = '0;
    if (rst_n && grant_found && s1_free) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  assign accept = |(bus.req_valid & ready_vec);

  // S1 and the pointer: load on accept, otherwise empty S1 once its content moves to S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_a       <= sel_a;
        s1_b       <= sel_b;
        s1_id      <= grant_idx;
        last_grant <= grant_idx;
      end else if (s2_load) begin
        s1_valid   <= 1'b0;
      end
    end
  end

  // S2: capture the shifter result for S1's operands, and hold it until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_data  <= bus.sh_result;
        s2_id    <= s1_id;
      end else if (s2_drain) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.sh_a      = s1_a;
  assign bus.sh_b      = s1_b;
  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_data  = s2_data;
  assign bus.rsp_id    = s2_id;
  assign bus.busy      = s1_valid || s2_valid;

endmodule
